// File: rtl/mips_io_responder.sv
// mips_io_responder: memory-mapped I/O block for a MIPS-style load/store bus.
// Provides a registered output port, a synchronized input port with change
// detection, a down-counting timer with one-shot/auto-reload modes, and a
// level interrupt built from the status flags and their enables.
module mips_io_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned IN_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  output logic [31:0]         ReadData,
  output logic                ReadValid,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                IRQ
);

  // Word index of each register inside the 32-byte window.
  localparam logic [2:0] RegOut    = 3'd0;
  localparam logic [2:0] RegIn     = 3'd1;
  localparam logic [2:0] RegStatus = 3'd2;
  localparam logic [2:0] RegTload  = 3'd3;
  localparam logic [2:0] RegTcount = 3'd4;
  localparam logic [2:0] RegCtrl   = 3'd5;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       selected;
  logic [2:0] regIdx;
  logic       wrSel;
  logic       rdSel;
  logic       wrOut;
  logic       wrStatus;
  logic       wrTload;
  logic       wrCtrl;

  assign selected = (Address[31:5] == BASE_ADDR[31:5]);
  assign regIdx   = Address[4:2];
  assign wrSel    = MemWrite & selected;
  // A simultaneous store turns the access into a write only.
  assign rdSel    = MemRead & ~MemWrite & selected;

  assign wrOut    = wrSel & (regIdx == RegOut);
  assign wrStatus = wrSel & (regIdx == RegStatus);
  assign wrTload  = wrSel & (regIdx == RegTload);
  assign wrCtrl   = wrSel & (regIdx == RegCtrl);

  // Byte lane bits are don't-care for word-wide registers.
  logic unusedAddrBits;
  assign unusedAddrBits = ^Address[1:0];

  // ---------------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------------
  logic [31:0]         outReg;
  logic [31:0]         tloadReg;
  logic [31:0]         tcountReg;
  logic [3:0]          ctrlReg;
  logic                chgFlag;
  logic                texpFlag;
  logic [IN_WIDTH-1:0] syncMeta;
  logic [IN_WIDTH-1:0] syncIn;
  logic [IN_WIDTH-1:0] prevIn;

  logic ctrlTen;
  logic ctrlAuto;
  logic ctrlChgIe;
  logic ctrlTie;

  assign ctrlTen   = ctrlReg[0];
  assign ctrlAuto  = ctrlReg[1];
  assign ctrlChgIe = ctrlReg[2];
  assign ctrlTie   = ctrlReg[3];

  // ---------------------------------------------------------------------------
  // Output port register
  // ---------------------------------------------------------------------------
  // OUT holds the last value stored to offset 0x00 and drives PortOut directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      outReg <= '0;
    end else if (wrOut) begin
      outReg <= WriteData;
    end
  end

  assign PortOut = outReg;

  // ---------------------------------------------------------------------------
  // Input synchronizer and change detector
  // ---------------------------------------------------------------------------
  // Two flops for metastability, a third holds the prior settled value.
  always_ff @(posedge clk) begin
    if (reset) begin
      syncMeta <= '0;
      syncIn   <= '0;
      prevIn   <= '0;
    end else begin
      syncMeta <= PortIn;
      syncIn   <= syncMeta;
      prevIn   <= syncIn;
    end
  end

  logic inChanged;
  assign inChanged = (syncIn != prevIn);

  // ---------------------------------------------------------------------------
  // Timer next-state
  // ---------------------------------------------------------------------------
  logic        timerExpire;
  logic        oneShotDone;
  logic [31:0] tcountNext;

  assign timerExpire = ctrlTen & (tcountReg == 32'd0);
  assign oneShotDone = timerExpire & ~ctrlAuto;

  // A TLOAD store overrides whatever the running timer would do this cycle.
  always_comb begin
    tcountNext = tcountReg;
    if (wrTload) begin
      tcountNext = WriteData;
    end else if (ctrlTen) begin
      if (tcountReg != 32'd0) begin
        tcountNext = tcountReg - 32'd1;
      end else if (ctrlAuto) begin
        tcountNext = tloadReg;
      end
    end
  end

  // Timer reload value and live count.
  always_ff @(posedge clk) begin
    if (reset) begin
      tloadReg  <= '0;
      tcountReg <= '0;
    end else begin
      if (wrTload) begin
        tloadReg <= WriteData;
      end
      tcountReg <= tcountNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Control register
  // ---------------------------------------------------------------------------
  // A CTRL store wins over the one-shot auto-clear of TEN, so software that
  // re-arms on the expiry cycle keeps the timer running.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlReg <= '0;
    end else if (wrCtrl) begin
      ctrlReg <= WriteData[3:0];
    end else if (oneShotDone) begin
      ctrlReg[0] <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Status flags
  // ---------------------------------------------------------------------------
  logic chgClear;
  logic texpClear;

  assign chgClear  = wrStatus & WriteData[0];
  assign texpClear = wrStatus & WriteData[1];

  // Sticky event flags, write-1-to-clear; a new event beats a clear so none is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      chgFlag  <= 1'b0;
      texpFlag <= 1'b0;
    end else begin
      chgFlag  <= inChanged | (chgFlag & ~chgClear);
      texpFlag <= timerExpire | (texpFlag & ~texpClear);
    end
  end

  // Level interrupt straight from the flags and enables.
  assign IRQ = (chgFlag & ctrlChgIe) | (texpFlag & ctrlTie);

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [31:0] readMux;

  // Select the addressed register; reserved slots read as zero.
  always_comb begin
    readMux = '0;
    case (regIdx)
      RegOut:    readMux = outReg;
      RegIn:     readMux = 32'(syncIn);
      RegStatus: readMux = {30'd0, texpFlag, chgFlag};
      RegTload:  readMux = tloadReg;
      RegTcount: readMux = tcountReg;
      RegCtrl:   readMux = {28'd0, ctrlReg};
      default:   readMux = '0;
    endcase
  end

  // One-cycle read response; data is forced to zero when no response is due.
  always_ff @(posedge clk) begin
    if (reset) begin
      ReadValid <= 1'b0;
      ReadData  <= '0;
    end else begin
      ReadValid <= rdSel;
      ReadData  <= rdSel ? readMux : 32'd0;
    end
  end

endmodule

// File: doc/mips_io_responder.md
MIPS_IO_RESPONDER -- requirements
Module: mips_io_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000, meaning the byte address of register offset 0x00; the block decodes the window BASE_ADDR..BASE_ADDR+0x1F.
REQ-002 SHALL have parameter IN_WIDTH, default 8, meaning the width of PortIn.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port MemRead, input, 1 bit: processor load strobe, one cycle per access.
REQ-007 SHALL have port MemWrite, input, 1 bit: processor store strobe, one cycle per access.
REQ-008 SHALL have port Address, input, 32 bits: processor byte address.
REQ-009 SHALL have port WriteData, input, 32 bits: store data.
REQ-010 SHALL have port ReadData, output, 32 bits: load data.
REQ-011 SHALL have port ReadValid, output, 1 bit: ReadData is valid this cycle.
REQ-012 SHALL have port PortIn, input, IN_WIDTH bits: asynchronous external input pins.
REQ-013 SHALL have port PortOut, output, 32 bits: registered external output port.
REQ-014 SHALL have port IRQ, output, 1 bit: level interrupt request to the processor.

Function
REQ-015 SHALL select the block when Address[31:5]==BASE_ADDR[31:5]; SHALL decode the register by Address[4:2] and SHALL ignore Address[1:0].
REQ-016 SHALL implement this register map: 0x00 OUT (RW, drives PortOut); 0x04 IN (RO, synchronized PortIn zero-extended); 0x08 STATUS (bit0 CHG, bit1 TEXP; write-1-to-clear); 0x0C TLOAD (RW); 0x10 TCOUNT (RO); 0x14 CTRL (RW, bits[3:0] only: bit0 TEN, bit1 AUTO, bit2 CHGIE, bit3 TIE; reads return the upper bits as 0); 0x18 and 0x1C are reserved and read 0, with writes ignored.
REQ-017 SHALL update the selected register on the clock edge where MemWrite=1.
REQ-018 SHALL, when MemRead=1 and the block is selected, assert ReadValid=1 and drive ReadData with the register value on the next cycle (1-cycle latency); otherwise ReadValid=0 and ReadData=0.
REQ-019 SHALL treat MemRead=1 and MemWrite=1 in the same cycle as a write only, with ReadValid=0 on the next cycle.
REQ-020 SHALL ignore any access that is not selected; no register changes.
REQ-021 SHALL pass PortIn through a 2-flop synchronizer; IN returns the stage-2 value.
REQ-022 SHALL set CHG on the cycle after the stage-2 value differs from its previous value.
REQ-023 SHALL let a set of CHG or TEXP in the same cycle as its write-1-to-clear win, so the bit stays 1.
REQ-024 SHALL, on a write to TLOAD, load both TLOAD and TCOUNT with WriteData.
REQ-025 SHALL decrement TCOUNT by 1 each cycle while TEN=1 and TCOUNT!=0.
REQ-026 SHALL, when TEN=1 and TCOUNT==0, set TEXP and then either reload TCOUNT<=TLOAD if AUTO=1, or clear TEN if AUTO=0 (one-shot).
REQ-027 SHALL, with TLOAD=0, TEN=1 and AUTO=1, set TEXP every cycle.
REQ-028 SHALL give a TLOAD write priority over the decrement or reload in the same cycle.
REQ-029 SHALL, when a CTRL write in the same cycle as a one-shot expiry writes TEN=1, leave TEN at 1, with TEXP still set.
REQ-030 SHALL drive IRQ = (CHG & CHGIE) | (TEXP & TIE) combinationally from the registers.

Reset
REQ-031 SHALL, on reset=1 at a clock edge, clear OUT, TLOAD, TCOUNT, CTRL, STATUS, the synchronizer and the previous-value flops to 0, giving PortOut=0, ReadData=0, ReadValid=0 and IRQ=0 on the following cycle.
REQ-032 SHALL let reset take priority over any simultaneous access or timer event and SHALL drop any pending read response.

Verification
REQ-033 Write 0x0000_00A5 to BASE+0x00, then read BASE+0x00 -> PortOut=0xA5 on the next cycle; ReadValid=1 and ReadData=0xA5 exactly one cycle after MemRead.
REQ-034 PortIn changes 0x00->0x3C with CTRL=0x4 -> IN reads 0x3C once the synchronizer settles; CHG=1 and IRQ=1 within 3 cycles of the change; writing 0x1 to STATUS clears CHG and IRQ.
REQ-035 TLOAD=3 with CTRL=0x9 (TEN, TIE, one-shot) -> TCOUNT steps 3,2,1,0; TEXP=1 and IRQ=1 at the zero cycle; TEN reads 0 afterwards; TCOUNT holds at 0.
REQ-036 TLOAD=2 with CTRL=0x3 (TEN, AUTO) -> TEXP sets every 3 cycles; a W1C on the expiry cycle leaves TEXP=1.
REQ-037 Read at BASE+0x20 and read with MemWrite=1 in the same cycle -> ReadValid=0 and ReadData=0; an unselected write changes no register.
REQ-038 Assert reset mid-countdown with a read pending -> all registers 0, ReadValid=0 and IRQ=0 on the next cycle.
